// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared types, parameter defaults and width helper for the
// regfile write-port arbiter.
//   clog2_min1(n) : address/index width for n items, never less than 1
//   wr_req_t      : one writeback request payload at default widths
package regfile_arb_pkg;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int N_ENTRIES_DEF     = 4;
  localparam int ENTRY_WIDTH_DEF   = 4;
  localparam int N_REQ_DEF         = 4;
  localparam int N_WRITE_PORTS_DEF = 2;
  localparam int N_READ_PORTS_DEF  = 2;
  localparam int PTR_WIDTH_DEF     = clog2_min1(N_ENTRIES_DEF);

  typedef struct packed {
    logic [PTR_WIDTH_DEF-1:0]   addr;
    logic [ENTRY_WIDTH_DEF-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rr_conflict_select.sv
// rr_conflict_select: combinational rotating scan for the write arbiter.
// Walks requesters from rr_ptr upward (mod N_REQ), granting each valid one
// whose address is not already claimed this cycle, until the write ports run
// out. The k-th grant lands on port k.
//   valid/addr  : requester valid bits and target entries
//   rr_ptr      : first requester scanned
//   grant       : per-requester grant
//   port_en     : port k carries a grant
//   port_idx    : requester driving port k
//   last_idx    : last requester granted (rr_ptr when nothing granted)
//   any_grant   : at least one grant this cycle
module rr_conflict_select #(
  parameter int N_REQ         = 4,
  parameter int N_WRITE_PORTS = 2,
  parameter int AW            = 2,
  parameter int IW            = 2
) (
  input  logic [N_REQ-1:0]                  valid,
  input  logic [N_REQ-1:0][AW-1:0]          addr,
  input  logic [IW-1:0]                     rr_ptr,
  output logic [N_REQ-1:0]                  grant,
  output logic [N_WRITE_PORTS-1:0]          port_en,
  output logic [N_WRITE_PORTS-1:0][IW-1:0]  port_idx,
  output logic [IW-1:0]                     last_idx,
  output logic                              any_grant
);

  logic [N_WRITE_PORTS-1:0][AW-1:0] port_addr;
  logic [IW-1:0]                    idx;
  logic                             clash;
  int                               cnt;

  always_comb begin
    grant     = '0;
    port_en   = '0;
    port_idx  = '0;
    port_addr = '0;
    last_idx  = rr_ptr;
    idx       = '0;
    clash     = 1'b0;
    cnt       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx   = IW'((int'(rr_ptr) + k) % N_REQ);
      // Same-address requesters later in rotation wait, so one port per entry.
      clash = 1'b0;
      for (int p = 0; p < N_WRITE_PORTS; p++)
        if (port_en[p] && port_addr[p] == addr[idx]) clash = 1'b1;
      if (valid[idx] && !clash && cnt < N_WRITE_PORTS) begin
        grant[idx] = 1'b1;
        for (int p = 0; p < N_WRITE_PORTS; p++)
          if (p == cnt) begin
            port_en[p]   = 1'b1;
            port_idx[p]  = idx;
            port_addr[p] = addr[idx];
          end
        last_idx = idx;
        cnt      = cnt + 1;
      end
    end
  end

  assign any_grant = |grant;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares N_WRITE_PORTS regfile write ports among N_REQ
// writeback requesters with round-robin priority and per-cycle address
// conflict avoidance. Write ports are driven from registers; the regfile
// commits one edge after the grant is registered.
//   clk, rst_aH                 : clock, async active-high reset
//   req_valid/addr/data, ready  : requester handshake (transfer on valid&ready)
//   wr_en/wr_addr/wr_data       : registered regfile write ports
//   rd_addr, fwd_hit, fwd_data  : read-port snoop for in-flight writes
// Build option: REGFILE_WR_ARB_FWD_EN enables the forwarding compare;
// otherwise fwd_hit/fwd_data are tied to zero.
module regfile_wr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int N_ENTRIES     = N_ENTRIES_DEF,
  parameter int ENTRY_WIDTH   = ENTRY_WIDTH_DEF,
  parameter int N_REQ         = N_REQ_DEF,
  parameter int N_WRITE_PORTS = N_WRITE_PORTS_DEF,
  parameter int N_READ_PORTS  = N_READ_PORTS_DEF,
  localparam int PTR_WIDTH    = clog2_min1(N_ENTRIES)
) (
  input  logic                                        clk,
  input  logic                                        rst_aH,
  input  logic [N_REQ-1:0]                            req_valid,
  input  logic [N_REQ-1:0][PTR_WIDTH-1:0]             req_addr,
  input  logic [N_REQ-1:0][ENTRY_WIDTH-1:0]           req_data,
  output logic [N_REQ-1:0]                            req_ready,
  output logic [N_WRITE_PORTS-1:0]                    wr_en,
  output logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]     wr_addr,
  output logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0]   wr_data,
  input  logic [N_READ_PORTS-1:0][PTR_WIDTH-1:0]      rd_addr,
  output logic [N_READ_PORTS-1:0]                     fwd_hit,
  output logic [N_READ_PORTS-1:0][ENTRY_WIDTH-1:0]    fwd_data
);

  localparam int IW = clog2_min1(N_REQ);

  logic [IW-1:0]                    rr_ptr;
  logic [N_REQ-1:0]                 grant;
  logic [N_WRITE_PORTS-1:0]         port_en;
  logic [N_WRITE_PORTS-1:0][IW-1:0] port_idx;
  logic [IW-1:0]                    last_idx;
  logic                             any_grant;

  rr_conflict_select #(
    .N_REQ         (N_REQ),
    .N_WRITE_PORTS (N_WRITE_PORTS),
    .AW            (PTR_WIDTH),
    .IW            (IW)
  ) u_sel (
    .valid     (req_valid),
    .addr      (req_addr),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .port_en   (port_en),
    .port_idx  (port_idx),
    .last_idx  (last_idx),
    .any_grant (any_grant)
  );

  // No handshake can complete while reset is held.
  assign req_ready = grant & {N_REQ{~rst_aH}};

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      rr_ptr  <= '0;
      wr_en   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= port_en;
      // Idle ports keep their last addr/data.
      for (int p = 0; p < N_WRITE_PORTS; p++)
        if (port_en[p]) begin
          wr_addr[p] <= req_addr[port_idx[p]];
          wr_data[p] <= req_data[port_idx[p]];
        end
      if (any_grant)
        rr_ptr <= (last_idx == IW'(N_REQ - 1)) ? '0 : last_idx + 1'b1;
    end
  end

`ifdef REGFILE_WR_ARB_FWD_EN
  // Selection never puts one address on two ports, so at most one match.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    for (int r = 0; r < N_READ_PORTS; r++)
      for (int p = 0; p < N_WRITE_PORTS; p++)
        if (wr_en[p] && wr_addr[p] == rd_addr[r]) begin
          fwd_hit[r]  = 1'b1;
          fwd_data[r] = wr_data[p];
        end
  end
`else
  assign fwd_hit  = '0;
  assign fwd_data = '0;
  logic unused_rd;
  assign unused_rd = ^rd_addr;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed bench for regfile_wr_arbiter with
// N_REQ=4, N_WRITE_PORTS=2, 4x4-bit regfile modelled locally.
module tb_regfile_wr_arbiter;

  logic             clk;
  logic             rst_aH;
  logic [3:0]       req_valid;
  logic [3:0][1:0]  req_addr;
  logic [3:0][3:0]  req_data;
  logic [3:0]       req_ready;
  logic [1:0]       wr_en;
  logic [1:0][1:0]  wr_addr;
  logic [1:0][3:0]  wr_data;
  logic [1:0][1:0]  rd_addr;
  logic [1:0]       fwd_hit;
  logic [1:0][3:0]  fwd_data;

  int checks;
  int failures;

  logic [3:0] mem [4];

  regfile_wr_arbiter #(
    .N_ENTRIES(4), .ENTRY_WIDTH(4), .N_REQ(4), .N_WRITE_PORTS(2), .N_READ_PORTS(2)
  ) dut (
    .clk(clk), .rst_aH(rst_aH),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile model: commits registered write ports on the rising edge.
  always @(posedge clk) begin
    for (int p = 0; p < 2; p++)
      if (wr_en[p]) mem[wr_addr[p]] <= wr_data[p];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  task automatic do_reset;
    rst_aH = 1'b1;
    clr_req();
    step();
    rst_aH = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst_aH = 1'b1;
    clr_req();
    rd_addr = '0;
    mem[0] = 4'ha; mem[1] = 4'hb; mem[2] = 4'hc; mem[3] = 4'hd;
    req_valid = 4'b0001;
    step();
    step();
    checks++;
    if (wr_en !== 2'b00) begin failures++; $display("FAIL rst_wr_en got=%b exp=00", wr_en); end
    checks++;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
    checks++;
    if (dut.rr_ptr !== 2'd0) begin failures++; $display("FAIL rst_rr_ptr got=%0d exp=0", dut.rr_ptr); end
    checks++;
    if (wr_addr !== 4'b0 || wr_data !== 8'b0) begin failures++; $display("FAIL rst_wr_payload got=%h/%h exp=0/0", wr_addr, wr_data); end
    // First cycle after reset may grant; then reset mid-run drops the write.
    rst_aH = 1'b0;
    req_valid = 4'b0011;
    req_addr[0] = 2'd0; req_data[0] = 4'h7;
    req_addr[1] = 2'd1; req_data[1] = 4'h8;
    #1;
    checks++;
    if (req_ready !== 4'b0011) begin failures++; $display("FAIL rst_first_grant got=%b exp=0011", req_ready); end
    step();
    checks++;
    if (wr_en !== 2'b11) begin failures++; $display("FAIL rst_pre_wr_en got=%b exp=11", wr_en); end
    rst_aH = 1'b1;
    #1;
    checks++;
    if (wr_en !== 2'b00) begin failures++; $display("FAIL rst_mid_wr_en got=%b exp=00", wr_en); end
    checks++;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_mid_ready got=%b exp=0000", req_ready); end
    checks++;
    if (dut.rr_ptr !== 2'd0) begin failures++; $display("FAIL rst_mid_rr_ptr got=%0d exp=0", dut.rr_ptr); end
    checks++;
    if (fwd_hit !== 2'b00) begin failures++; $display("FAIL rst_fwd_hit got=%b exp=00", fwd_hit); end
    step();
    checks++;
    if (mem[0] !== 4'ha || mem[1] !== 4'hb) begin failures++; $display("FAIL rst_no_commit got=%h,%h exp=a,b", mem[0], mem[1]); end
    clr_req();
    rst_aH = 1'b0;
    #1;
  endtask

  task automatic test_basic;
    logic [1:0] exp_hit;
    logic [3:0] exp_fd0;
`ifdef REGFILE_WR_ARB_FWD_EN
    exp_hit = 2'b01; exp_fd0 = 4'he;
`else
    exp_hit = 2'b00; exp_fd0 = 4'h0;
`endif
    rd_addr[0] = 2'd2; rd_addr[1] = 2'd0;
    req_valid = 4'b0011;
    req_addr[0] = 2'd2; req_data[0] = 4'he;
    req_addr[1] = 2'd3; req_data[1] = 4'hf;
    #1;
    checks++;
    if (req_ready !== 4'b0011) begin failures++; $display("FAIL basic_ready got=%b exp=0011", req_ready); end
    step();
    clr_req();
    checks++;
    if (wr_en !== 2'b11) begin failures++; $display("FAIL basic_wr_en got=%b exp=11", wr_en); end
    checks++;
    if (wr_addr !== {2'd3, 2'd2}) begin failures++; $display("FAIL basic_wr_addr got=%h exp=e", wr_addr); end
    checks++;
    if (wr_data !== {4'hf, 4'he}) begin failures++; $display("FAIL basic_wr_data got=%h exp=fe", wr_data); end
    checks++;
    if (fwd_hit !== exp_hit) begin failures++; $display("FAIL fwd_hit got=%b exp=%b", fwd_hit, exp_hit); end
    checks++;
    if (fwd_data[0] !== exp_fd0) begin failures++; $display("FAIL fwd_data0 got=%h exp=%h", fwd_data[0], exp_fd0); end
    step();
    checks++;
    if ({mem[3], mem[2], mem[1], mem[0]} !== 16'hfeba) begin
      failures++; $display("FAIL basic_commit got=%h exp=feba", {mem[3], mem[2], mem[1], mem[0]});
    end
    checks++;
    if (wr_en !== 2'b00 || wr_addr !== {2'd3, 2'd2}) begin failures++; $display("FAIL basic_hold got=%b/%h exp=00/e", wr_en, wr_addr); end
    checks++;
    if (dut.rr_ptr !== 2'd2) begin failures++; $display("FAIL basic_rr_ptr got=%0d exp=2", dut.rr_ptr); end
    rd_addr = '0;
  endtask

  task automatic test_rotation;
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_addr[i] = 2'(i);
      req_data[i] = 4'(i + 1);
    end
    #1;
    checks++;
    if (req_ready !== 4'b0011) begin failures++; $display("FAIL rot_c1_ready got=%b exp=0011", req_ready); end
    step();
    checks++;
    if (dut.rr_ptr !== 2'd2 || wr_addr !== {2'd1, 2'd0}) begin failures++; $display("FAIL rot_c1 got=%0d/%h exp=2/4", dut.rr_ptr, wr_addr); end
    checks++;
    if (req_ready !== 4'b1100) begin failures++; $display("FAIL rot_c2_ready got=%b exp=1100", req_ready); end
    step();
    checks++;
    if (dut.rr_ptr !== 2'd0 || wr_data !== {4'h4, 4'h3}) begin failures++; $display("FAIL rot_c2 got=%0d/%h exp=0/43", dut.rr_ptr, wr_data); end
    checks++;
    if (req_ready !== 4'b0011) begin failures++; $display("FAIL rot_c3_ready got=%b exp=0011", req_ready); end
    step();
    clr_req();
  endtask

  task automatic test_conflict;
    do_reset();
    step();
    req_valid = 4'b0011;
    req_addr[0] = 2'd1; req_data[0] = 4'h5;
    req_addr[1] = 2'd1; req_data[1] = 4'h6;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL conf_c1_ready got=%b exp=0001", req_ready); end
    step();
    req_valid = 4'b0010;
    checks++;
    if (wr_en !== 2'b01 || wr_addr[0] !== 2'd1 || wr_data[0] !== 4'h5) begin
      failures++; $display("FAIL conf_c1_port got=%b/%h/%h exp=01/1/5", wr_en, wr_addr[0], wr_data[0]);
    end
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL conf_c2_ready got=%b exp=0010", req_ready); end
    step();
    clr_req();
    checks++;
    if (wr_en !== 2'b01 || wr_data[0] !== 4'h6 || mem[1] !== 4'h5) begin
      failures++; $display("FAIL conf_c2_port got=%b/%h mem1=%h exp=01/6 mem1=5", wr_en, wr_data[0], mem[1]);
    end
    step();
    checks++;
    if (mem[1] !== 4'h6) begin failures++; $display("FAIL conf_final got=%h exp=6", mem[1]); end
  endtask

  task automatic test_single_wrap;
    do_reset();
    req_valid = 4'b0001;
    step();
    clr_req();
    step();
    checks++;
    if (dut.rr_ptr !== 2'd1) begin failures++; $display("FAIL wrap_setup got=%0d exp=1", dut.rr_ptr); end
    req_valid = 4'b1000;
    req_addr[3] = 2'd0; req_data[3] = 4'h9;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin failures++; $display("FAIL single_ready got=%b exp=1000", req_ready); end
    step();
    clr_req();
    checks++;
    if (wr_en !== 2'b01 || wr_addr[0] !== 2'd0 || wr_data[0] !== 4'h9 || dut.rr_ptr !== 2'd0) begin
      failures++; $display("FAIL single_port got=%b/%h/%h ptr=%0d exp=01/0/9 ptr=0", wr_en, wr_addr[0], wr_data[0], dut.rr_ptr);
    end
    // Drive rr_ptr to 3, then requesters 3 and 0 wrap: port 0 = req 3.
    req_valid = 4'b0100;
    step();
    checks++;
    if (dut.rr_ptr !== 2'd3) begin failures++; $display("FAIL wrap_ptr3 got=%0d exp=3", dut.rr_ptr); end
    req_valid = 4'b1001;
    req_addr[0] = 2'd1; req_data[0] = 4'ha;
    req_addr[3] = 2'd2; req_data[3] = 4'hb;
    #1;
    checks++;
    if (req_ready !== 4'b1001) begin failures++; $display("FAIL wrap_ready got=%b exp=1001", req_ready); end
    step();
    clr_req();
    checks++;
    if (wr_addr !== {2'd1, 2'd2} || wr_data !== {4'ha, 4'hb} || dut.rr_ptr !== 2'd1) begin
      failures++; $display("FAIL wrap_ports got=%h/%h ptr=%0d exp=6/ab ptr=1", wr_addr, wr_data, dut.rr_ptr);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_rotation();
    test_conflict();
    test_single_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
